// File: rtl/dual_core_mem_arbiter_pkg.sv
// Shared definitions for the dual-core memory arbiter.
// Holds the arbiter FSM state encoding, the core ID constants and the
// default address width derived from the default memory depth.
package dual_core_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

    localparam int MEM_SIZE_DEFAULT = 256;
    localparam int AW               = $clog2(MEM_SIZE_DEFAULT);

endpackage

// File: rtl/dual_core_mem_arbiter_return.sv
// Per-core read-return port.
// Shows the live memory read data on the cycle a read issued by this core
// returns, and otherwise replays the last word this core received.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   ret_sel       - this cycle carries a read return owned by this core
//   mem_read_val  - registered read data from the memory controller
//   read_val      - data presented to the core (0 while reset is high)
module mem_arb_return_port #(
    parameter int MEM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ret_sel,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic [MEM_WIDTH-1:0] read_val
);

    logic [MEM_WIDTH-1:0] hold_q;
    logic [MEM_WIDTH-1:0] hold_d;

    always_comb begin
        hold_d = ret_sel ? mem_read_val : hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Bypass on the return cycle keeps the one-cycle read latency of a
    // direct core-to-memory connection.
    always_comb begin
        if (reset) begin
            read_val = '0;
        end else if (ret_sel) begin
            read_val = mem_read_val;
        end else begin
            read_val = hold_q;
        end
    end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Two-master arbiter between two cores and a single-ported memory controller.
// One access per clock, round-robin on contention, optional per-core bus lock
// with a watchdog that force-releases a lock held LOCK_MAX_CYCLES cycles.
// Ports:
//   cN_mem_*       - core N request side (addr, read/write enables, write data,
//                    lock) and response side (stall, read data)
//   mem_*          - memory controller side; all zero when nothing is granted
//   lock_timeout   - sticky flag, set when the watchdog breaks a lock
module dual_core_mem_arbiter
    import dual_core_mem_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH       = 32,
    parameter int MEM_SIZE        = 256,
    parameter int LOCK_MAX_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(MEM_SIZE)-1:0] c0_mem_addr,
    input  logic                        c0_mem_read_en,
    input  logic                        c0_mem_write_en,
    input  logic [MEM_WIDTH-1:0]        c0_mem_write_val,
    input  logic                        c0_mem_lock,
    output logic                        c0_mem_stall,
    output logic [MEM_WIDTH-1:0]        c0_mem_read_val,
    input  logic [$clog2(MEM_SIZE)-1:0] c1_mem_addr,
    input  logic                        c1_mem_read_en,
    input  logic                        c1_mem_write_en,
    input  logic [MEM_WIDTH-1:0]        c1_mem_write_val,
    input  logic                        c1_mem_lock,
    output logic                        c1_mem_stall,
    output logic [MEM_WIDTH-1:0]        c1_mem_read_val,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    output logic [MEM_WIDTH-1:0]        mem_write_val,
    input  logic [MEM_WIDTH-1:0]        mem_read_val,
    output logic                        lock_timeout
);

    localparam int CW = $clog2(LOCK_MAX_CYCLES + 1) + 1;

    arb_state_e    state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_timeout_q, lock_timeout_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;

    logic          req0, req1;
    logic          grant0, grant1;
    logic          lock_in;
    logic [CW-1:0] lock_cnt_inc;

    // Requests are ignored while reset is high, which also forces stalls low.
    assign req0 = ~reset & (c0_mem_read_en | c0_mem_write_en);
    assign req1 = ~reset & (c1_mem_read_en | c1_mem_write_en);

    assign lock_in      = (state_q == ARB_LOCK1) ? c1_mem_lock : c0_mem_lock;
    assign lock_cnt_inc = lock_cnt_q + CW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            rr_last_q      <= CORE1;
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_owner_q     <= CORE0;
        end else begin
            state_q        <= state_d;
            rr_last_q      <= rr_last_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
            rd_pend_q      <= rd_pend_d;
            rd_owner_q     <= rd_owner_d;
        end
    end

    // Grant and memory-side mux
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    // The core that did not win last time gets the bus.
                    grant0 = (rr_last_q == CORE1);
                    grant1 = (rr_last_q == CORE0);
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
            end
            ARB_LOCK0: grant0 = req0;
            ARB_LOCK1: grant1 = req1;
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase

        mem_addr      = '0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_write_val = '0;
        if (grant0) begin
            mem_addr      = c0_mem_addr;
            mem_read_en   = c0_mem_read_en & ~c0_mem_write_en;
            mem_write_en  = c0_mem_write_en;
            mem_write_val = c0_mem_write_val;
        end else if (grant1) begin
            mem_addr      = c1_mem_addr;
            mem_read_en   = c1_mem_read_en & ~c1_mem_write_en;
            mem_write_en  = c1_mem_write_en;
            mem_write_val = c1_mem_write_val;
        end
    end

    assign c0_mem_stall = req0 & ~grant0;
    assign c1_mem_stall = req1 & ~grant1;
    assign lock_timeout = lock_timeout_q & ~reset;

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = lock_timeout_q;
        rd_pend_d      = mem_read_en;
        rd_owner_d     = grant1;

        if (grant0) begin
            rr_last_d = CORE0;
        end else if (grant1) begin
            rr_last_d = CORE1;
        end

        case (state_q)
            ARB_IDLE: begin
                if ((grant0 && c0_mem_lock) || (grant1 && c1_mem_lock)) begin
                    if (LOCK_MAX_CYCLES <= 1) begin
                        // The grant cycle already uses the whole budget.
                        lock_timeout_d = 1'b1;
                    end else begin
                        state_d    = grant0 ? ARB_LOCK0 : ARB_LOCK1;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            ARB_LOCK0, ARB_LOCK1: begin
                if (!lock_in) begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_inc >= CW'(LOCK_MAX_CYCLES)) begin
                    // Watchdog: this cycle is the last one the holder gets;
                    // marking it as last winner hands the next tie over.
                    state_d        = ARB_IDLE;
                    lock_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                    rr_last_d      = (state_q == ARB_LOCK1) ? CORE1 : CORE0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Read-return ports, one per core
    logic [1:0]           ret_sel;
    logic [MEM_WIDTH-1:0] read_val [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign ret_sel[gi] = rd_pend_q & (rd_owner_q == 1'(gi));
            mem_arb_return_port #(
                .MEM_WIDTH(MEM_WIDTH)
            ) u_ret (
                .clk         (clk),
                .reset       (reset),
                .ret_sel     (ret_sel[gi]),
                .mem_read_val(mem_read_val),
                .read_val    (read_val[gi])
            );
        end
    endgenerate

    assign c0_mem_read_val = read_val[0];
    assign c1_mem_read_val = read_val[1];

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
module tb_dual_core_mem_arbiter;
    import dual_core_mem_arbiter_pkg::*;

    localparam int W    = 32;
    localparam int LMAX = 4;

    typedef struct packed {
        logic         core;
        logic [W-1:0] data;
    } ret_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] c0_mem_addr, c1_mem_addr;
    logic          c0_mem_read_en, c0_mem_write_en, c0_mem_lock;
    logic          c1_mem_read_en, c1_mem_write_en, c1_mem_lock;
    logic [W-1:0]  c0_mem_write_val, c1_mem_write_val;
    logic          c0_mem_stall, c1_mem_stall;
    logic [W-1:0]  c0_mem_read_val, c1_mem_read_val;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en, mem_write_en;
    logic [W-1:0]  mem_write_val, mem_read_val;
    logic          lock_timeout;

    dual_core_mem_arbiter #(
        .MEM_WIDTH(W),
        .MEM_SIZE(MEM_SIZE_DEFAULT),
        .LOCK_MAX_CYCLES(LMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .c0_mem_addr(c0_mem_addr),
        .c0_mem_read_en(c0_mem_read_en),
        .c0_mem_write_en(c0_mem_write_en),
        .c0_mem_write_val(c0_mem_write_val),
        .c0_mem_lock(c0_mem_lock),
        .c0_mem_stall(c0_mem_stall),
        .c0_mem_read_val(c0_mem_read_val),
        .c1_mem_addr(c1_mem_addr),
        .c1_mem_read_en(c1_mem_read_en),
        .c1_mem_write_en(c1_mem_write_en),
        .c1_mem_write_val(c1_mem_write_val),
        .c1_mem_lock(c1_mem_lock),
        .c1_mem_stall(c1_mem_stall),
        .c1_mem_read_val(c1_mem_read_val),
        .mem_addr(mem_addr),
        .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val),
        .mem_read_val(mem_read_val),
        .lock_timeout(lock_timeout)
    );

    // Memory controller model: registered read, write on the same edge.
    logic [W-1:0] mem_model [MEM_SIZE_DEFAULT];
    logic [W-1:0] mem_rdata;
    assign mem_read_val = mem_rdata;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE_DEFAULT; i++) begin
                mem_model[i] <= 32'h1000_0000 | W'(i);
            end
            mem_model[8] <= 32'h0000_00A5;
            mem_rdata    <= '0;
        end else begin
            if (mem_write_en) mem_model[mem_addr] <= mem_write_val;
            if (mem_read_en)  mem_rdata <= mem_model[mem_addr];
        end
    end

    int           checks = 0;
    int           errors = 0;
    ret_t         sb_q[$];
    logic [W-1:0] exp_hold0 = '0;
    logic [W-1:0] exp_hold1 = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [W-1:0] v0, input logic l0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [W-1:0] v1, input logic l1);
        c0_mem_read_en = r0; c0_mem_write_en = w0; c0_mem_addr = a0;
        c0_mem_write_val = v0; c0_mem_lock = l0;
        c1_mem_read_en = r1; c1_mem_write_en = w1; c1_mem_addr = a1;
        c1_mem_write_val = v1; c1_mem_lock = l1;
    endtask

    // One cycle with reset high: every output must be zero.
    task automatic rst_cycle(input string name);
        @(negedge clk);
        chk({name, ":mem_addr"}, W'(mem_addr), '0);
        chk({name, ":mem_read_en"}, W'(mem_read_en), '0);
        chk({name, ":mem_write_en"}, W'(mem_write_en), '0);
        chk({name, ":mem_write_val"}, mem_write_val, '0);
        chk({name, ":c0_stall"}, W'(c0_mem_stall), '0);
        chk({name, ":c1_stall"}, W'(c1_mem_stall), '0);
        chk({name, ":c0_read_val"}, c0_mem_read_val, '0);
        chk({name, ":c1_read_val"}, c1_mem_read_val, '0);
        chk({name, ":lock_timeout"}, W'(lock_timeout), '0);
        sb_q.delete();
        exp_hold0 = '0;
        exp_hold1 = '0;
        $display("[%0t] %s: reset cycle", $time, name);
        @(posedge clk);
        #1;
    endtask

    // One normal cycle; g is the expected grant (-1 none, 0 or 1).
    task automatic cycle(input string name, input int g, input logic exp_to);
        ret_t          r;
        logic [AW-1:0] ea;
        logic          er, ew, es0, es1;
        logic [W-1:0]  ev;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            if (r.core) exp_hold1 = r.data;
            else        exp_hold0 = r.data;
        end
        chk({name, ":c0_read_val"}, c0_mem_read_val, exp_hold0);
        chk({name, ":c1_read_val"}, c1_mem_read_val, exp_hold1);

        ea = '0; er = 1'b0; ew = 1'b0; ev = '0;
        if (g == 0) begin
            ea = c0_mem_addr; er = c0_mem_read_en & ~c0_mem_write_en;
            ew = c0_mem_write_en; ev = c0_mem_write_val;
        end else if (g == 1) begin
            ea = c1_mem_addr; er = c1_mem_read_en & ~c1_mem_write_en;
            ew = c1_mem_write_en; ev = c1_mem_write_val;
        end
        es0 = (c0_mem_read_en | c0_mem_write_en) && (g != 0);
        es1 = (c1_mem_read_en | c1_mem_write_en) && (g != 1);

        chk({name, ":mem_addr"}, W'(mem_addr), W'(ea));
        chk({name, ":mem_read_en"}, W'(mem_read_en), W'(er));
        chk({name, ":mem_write_en"}, W'(mem_write_en), W'(ew));
        chk({name, ":mem_write_val"}, mem_write_val, ev);
        chk({name, ":c0_stall"}, W'(c0_mem_stall), W'(es0));
        chk({name, ":c1_stall"}, W'(c1_mem_stall), W'(es1));
        chk({name, ":lock_timeout"}, W'(lock_timeout), W'(exp_to));

        if (er) begin
            r.core = (g == 1);
            r.data = mem_model[ea];
            sb_q.push_back(r);
        end
        $display("[%0t] %s: grant=%0d addr=%0d rd=%0b wr=%0b c0_rv=%h c1_rv=%h",
                 $time, name, g, mem_addr, mem_read_en, mem_write_en,
                 c0_mem_read_val, c1_mem_read_val);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        drive(1, 0, 8'd3, '0, 1, 1, 0, 8'd4, '0, 1);
        repeat (3) rst_cycle("reset");
        reset = 1'b0;

        // Single reader
        drive(1, 0, 8'd8, '0, 0, 0, 0, 8'd0, '0, 0);
        cycle("single_c0_rd8", 0, 1'b0);
        drive(0, 0, 8'd0, '0, 0, 0, 0, 8'd0, '0, 0);
        cycle("single_ret", -1, 1'b0);
        chk("a5_value", c0_mem_read_val, 32'h0000_00A5);
        drive(0, 0, 8'd0, '0, 0, 1, 0, 8'd3, '0, 0);
        cycle("single_c1_rd3", 1, 1'b0);

        // Contention: alternating grants starting with core 0
        drive(1, 0, 8'd1, '0, 0, 1, 0, 8'd2, '0, 0);
        for (int i = 0; i < 6; i++) cycle("contend", i % 2, 1'b0);

        // Core 0 write leaves core 1 as the next tie winner
        drive(0, 1, 8'd20, 32'hDEAD_BEEF, 0, 0, 0, 8'd0, '0, 0);
        cycle("c0_wr20", 0, 1'b0);

        // Lock by core 1 while core 0 keeps requesting
        drive(1, 0, 8'd1, '0, 0, 0, 1, 8'd5, 32'h5555_AAAA, 1);
        cycle("lock_c1_wr5", 1, 1'b0);
        drive(1, 0, 8'd1, '0, 0, 1, 0, 8'd5, '0, 1);
        cycle("lock_c1_rd5", 1, 1'b0);
        drive(1, 0, 8'd1, '0, 0, 0, 0, 8'd0, '0, 0);
        cycle("lock_c1_drop", -1, 1'b0);
        cycle("lock_c0_after", 0, 1'b0);

        // Watchdog: core 0 holds the lock indefinitely
        drive(1, 0, 8'd8, '0, 1, 0, 0, 8'd0, '0, 0);
        cycle("wd_c0_first", 0, 1'b0);
        drive(1, 0, 8'd8, '0, 1, 1, 0, 8'd2, '0, 0);
        for (int i = 0; i < LMAX - 1; i++) cycle("wd_c0_hold", 0, 1'b0);
        cycle("wd_c1_wins", 1, 1'b1);
        drive(0, 0, 8'd0, '0, 0, 0, 0, 8'd0, '0, 0);
        cycle("wd_sticky", -1, 1'b1);
        cycle("wd_sticky", -1, 1'b1);

        // Reset in the middle of a lock with a read pending
        drive(1, 0, 8'd8, '0, 1, 0, 0, 8'd0, '0, 0);
        cycle("rml_c0_lock", 0, 1'b1);
        reset = 1'b1;
        rst_cycle("rml_reset");
        reset = 1'b0;
        drive(1, 0, 8'd1, '0, 0, 1, 0, 8'd2, '0, 0);
        cycle("rml_c0_wins", 0, 1'b0);
        drive(0, 0, 8'd0, '0, 0, 0, 0, 8'd0, '0, 0);
        cycle("rml_ret", -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
Two-master arbiter between two Core instances and the single-ported MemoryController, in preparation for a second core running its own PC window. It grants one memory access per clock, round-robin on contention, and stalls the loser. It supports a per-core lock that holds the bus for read-modify-write sequences, with a watchdog that releases a stuck lock. It routes registered read data back to the core that issued the read.

Parameters:
MEM_WIDTH, 32, data word width.
MEM_SIZE, 256, words of memory; address width AW = $clog2(MEM_SIZE).
LOCK_MAX_CYCLES, 16, maximum consecutive cycles one core may hold a lock; must be ≥1.

Ports:
clk  in  1  system clock (the divided core clock); single clock domain.
reset  in  1  synchronous, active-high reset.
cN_mem_addr  in  AW  core N address (N = 0, 1; each port exists per core).
cN_mem_read_en  in  1  core N read request.
cN_mem_write_en  in  1  core N write request.
cN_mem_write_val  in  MEM_WIDTH  core N write data.
cN_mem_lock  in  1  core N requests bus ownership to continue after the current grant.
cN_mem_stall  out  1  core N request not accepted this cycle; core must hold the request.
cN_mem_read_val  out  MEM_WIDTH  read data returned to core N.
mem_addr  out  AW  to MemoryController.
mem_read_en  out  1  to MemoryController.
mem_write_en  out  1  to MemoryController.
mem_write_val  out  MEM_WIDTH  to MemoryController.
mem_read_val  in  MEM_WIDTH  from MemoryController; valid the cycle after mem_read_en.
lock_timeout  out  1  sticky flag, set when the watchdog force-releases a lock.

Behaviour:
- Request: reqN = cN_mem_read_en | cN_mem_write_en. Read and write both asserted counts as a write; mem_read_en is not driven in that case.
- Grant is combinational from the inputs plus registered state. The memory-side outputs mux the granted core's signals in the same cycle.
  - With no grant, all mem_* outputs are 0.
  - cN_mem_stall = reqN & ~grantN.
- States: IDLE, LOCK0, LOCK1.
  - IDLE:
    - One requester: it is granted.
    - Both requesting: the core other than rr_last is granted.
    - rr_last updates to the granted core on every grant.
    - If the granted core has cN_mem_lock = 1: go to LOCKN and load lock_cnt = 1.
  - LOCKN:
    - Only core N can be granted; the other core's request is stalled.
    - Core N with no request that cycle is allowed; the bus is idle and the lock is held.
    - Exit to IDLE at the end of the first cycle with cN_mem_lock = 0. That cycle's request is still granted to N.
    - Otherwise lock_cnt increments.
    - When lock_cnt reaches LOCK_MAX_CYCLES with the lock still asserted: grant N this cycle, go to IDLE, set lock_timeout, and set rr_last = N so the other core wins the next tie.
  - lock_timeout clears only on reset.
- Read return:
  - A registered rd_pend (1 bit) and rd_owner (1 bit) are set on a granted read.
  - In the following cycle, cN_mem_read_val = mem_read_val when rd_pend and rd_owner = N. Otherwise it shows holdN.
  - holdN captures mem_read_val on that return cycle.
  - Latency: request in cycle t, data at the core in cycle t+1. This matches a direct Core-to-MemoryController connection.
- Back-to-back reads by alternating cores each receive their own data. A write never disturbs either hold register.
- Reset values:
  - State IDLE, rr_last = 1 (core 0 wins the first tie), lock_cnt = 0, rd_pend = 0, hold0 = hold1 = 0, lock_timeout = 0.
  - All outputs 0 while reset is high. Stalls are forced to 0 during reset; requests are ignored.
- Reset mid-lock or mid-read: state returns to IDLE and the pending read is discarded. The next-cycle cN_mem_read_val is 0.
- Address and data pass through unmodified; no range checking or width arithmetic.

Decomposition:
- Shared package holds:
  - The state encoding (ARB_IDLE = 2'd0, ARB_LOCK0 = 2'd1, ARB_LOCK1 = 2'd2).
  - Core ID constants CORE0 = 1'b0, CORE1 = 1'b1.
  - The derived AW.
- One sub-module, mem_arb_return_port: per-core read-return hold register plus the output mux. Instantiated twice.
- The grant/FSM logic stays in the top level.

Test Plan:
- Reset: hold reset 3 cycles with both cores requesting -> all mem_* = 0, both stalls 0, both read_vals 0, lock_timeout 0.
- Single reader: c0 reads addr 8 (mem[8]=32'hA5) -> mem_addr=8 and mem_read_en=1 the same cycle; c0_mem_read_val=32'hA5 the next cycle; c1_mem_read_val unchanged.
- Contention: both cores read continuously (c0 addr 1, c1 addr 2) for 6 cycles -> grants alternate 0,1,0,1,0,1; each stall is high on alternate cycles; each core receives only its own word.
- Lock: c1 asserts lock with write addr 5 then read addr 5 over 3 cycles while c0 requests -> c0 stalled all 3 cycles; c0 granted the cycle after c1 drops lock.
- Watchdog: LOCK_MAX_CYCLES=4, c0 holds lock indefinitely while c1 requests -> c0 granted 4 cycles, lock_timeout rises, c1 granted in cycle 5, lock_timeout stays 1 until reset.
- Reset mid-lock: reset asserted in LOCK0 with a read pending -> next cycle state IDLE, c0_mem_read_val=0, round-robin restarts with core 0 winning.
